md_alu_ctrl: RTL and testbench
==============================

# md_alu_ctrl

Parametrised successor to the single-cycle ALU controller in the MIPS datapath. It performs the same combinational funct/ALUOp decode onto the 4-bit ALU control bus, and adds a sequential multiply/divide unit: WIDTH-bit signed/unsigned iterative multiply and divide into HI/LO registers, mthi/mtlo/mfhi/mflo, and a stall output that holds the PC while an operation runs. It sits in the execute stage beside the ALU. The writeback mux selects its result for mfhi/mflo.

## Interface
- WIDTH, 32, datapath/operand width, ≥ 4
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- funct_i  in  6  instruction funct field
- ALUOp_i  in  3  main-control ALU operation class
- valid_i  in  1  instruction in execute is valid
- rs_data_i  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_data_i  in  WIDTH  rt operand (divisor / multiplier)
- ALUCtrl_o  out  4  ALU control, combinational
- md_result_o  out  WIDTH  HI (mfhi) or LO (mflo), combinational
- md_result_sel_o  out  1  1 when decoded instruction is mfhi/mflo
- stall_o  out  1  hold PC / suppress writeback this cycle

## Operation
- Decode when ALUOp_i=010 (R-type):
  - add 100000→0010; sub 100010→0110; and 100100→0000; or 100101→0001; slt 101010→0111
  - sll 000000→0101; srlv 000110→1111
  - mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011→0000
  - any other funct→0000
- Decode for other ALUOp_i values: 110→0010; 011→0111; 001→0110; 100→0100; 111→0001; 000→1000; others→0000. No X outputs.
- md_result_sel_o=1 only for R-type mfhi/mflo. md_result_o=HI for mfhi, otherwise LO.
- mthi/mtlo: when valid_i and state IDLE, HI (or LO) ← rs_data_i at the clock edge. No stall.
- FSM states:
  - IDLE: start = valid_i & R-type & funct∈{mult,multu,div,divu}. On start, latch operands. For signed ops, take absolute values and latch the sign flags. Counter←0. Go to RUN.
  - RUN: one shift-add (mult) or one restoring subtract-shift (div) step per cycle. Counter increments. After WIDTH steps, go to FIX.
  - FIX: apply sign correction and write HI/LO at the clock edge. Go to IDLE.
- Sign rules:
  - Signed mult: negate the 2·WIDTH product if the operand signs differ.
  - Signed div: quotient is negated if the signs differ; remainder takes the dividend's sign.
- Result mapping: mult → {HI,LO} = product. div → LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = rs_data_i (dividend). Full latency still applies.
- Signed overflow (min ÷ −1): LO = min, HI = 0.
- While in RUN, valid_i and operand changes are ignored because the operands are latched. start is evaluated only in IDLE, so the held instruction does not restart in FIX.

## Timing
- Reset (synchronous): state=IDLE, counter=0, HI=0, LO=0. Outputs after reset: stall_o=0, md_result_o=0; combinational outputs follow the inputs.
- rst_i asserted mid-operation aborts the operation at that edge. HI/LO are cleared and no partial result is written.
- stall_o = start (combinational, while in IDLE) OR state==RUN. stall_o is 0 in FIX.
- Start in cycle T:
  - stall_o is high in cycles T..T+WIDTH (WIDTH+1 cycles).
  - FIX is cycle T+WIDTH+1.
  - HI/LO are visible from cycle T+WIDTH+2.
  - The instruction occupies WIDTH+2 cycles in total.
- Back-to-back: a md op in the cycle after FIX starts normally. mfhi in that cycle returns the new HI.
- mthi/mtlo during RUN/FIX cannot occur (PC held) and is ignored.

## Test plan
- Decode sweep: every listed ALUOp/funct pair → the listed ALUCtrl_o. funct 111111 with ALUOp 010 → 0000. md_result_sel_o is high only for 010000/010010.
- WIDTH=32, mult rs=0xFFFFFFFD (−3), rt=5 → stall_o high exactly 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- divu 100/7 → LO=14, HI=2. div −7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- div 123/0 → LO=0xFFFFFFFF, HI=123, latency 34 cycles.
- mthi 0xDEADBEEF, then mfhi → md_result_o=0xDEADBEEF, stall_o=0. mtlo 7, then mflo → 7.
- mult started, rst_i asserted at cycle T+10 → next cycle state IDLE, stall_o=0, HI=LO=0. Toggling rs/rt during RUN of an unreset operation does not change the result.

Source files
------------

// File: rtl/md_alu_ctrl.sv
// ALU control decode plus an iterative signed/unsigned multiply/divide unit with HI/LO registers.
// The unit does one shift-add or restoring-divide step per cycle and stalls the PC while it is busy.
module md_alu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       funct_i,
  input  logic [2:0]       ALUOp_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic [3:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] md_result_o,
  output logic             md_result_sel_o,
  output logic             stall_o
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               op_div_q, op_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;

  logic               is_rtype;
  logic               is_md_op;
  logic               is_signed;
  logic               start;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     shifted, trial, sum;
  logic [2*WIDTH-1:0] prod;

  // ALU control decode and mfhi/mflo result select
  always_comb begin
    ALUCtrl_o       = 4'b0000;
    is_rtype        = (ALUOp_i == 3'b010);
    md_result_sel_o = is_rtype && ((funct_i == F_MFHI) || (funct_i == F_MFLO));
    md_result_o     = (is_rtype && (funct_i == F_MFHI)) ? hi_q : lo_q;
    case (ALUOp_i)
      3'b010: begin
        case (funct_i)
          6'b100000: ALUCtrl_o = 4'b0010;
          6'b100010: ALUCtrl_o = 4'b0110;
          6'b100100: ALUCtrl_o = 4'b0000;
          6'b100101: ALUCtrl_o = 4'b0001;
          6'b101010: ALUCtrl_o = 4'b0111;
          6'b000000: ALUCtrl_o = 4'b0101;
          6'b000110: ALUCtrl_o = 4'b1111;
          default:   ALUCtrl_o = 4'b0000;
        endcase
      end
      3'b110:  ALUCtrl_o = 4'b0010;
      3'b011:  ALUCtrl_o = 4'b0111;
      3'b001:  ALUCtrl_o = 4'b0110;
      3'b100:  ALUCtrl_o = 4'b0100;
      3'b111:  ALUCtrl_o = 4'b0001;
      3'b000:  ALUCtrl_o = 4'b1000;
      default: ALUCtrl_o = 4'b0000;
    endcase
  end

  // Multiply/divide FSM next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opa_d     = opa_q;
    dvd_d     = dvd_q;
    op_div_d  = op_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    // funct bit 0 clear marks the signed variants (mult, div)
    is_md_op  = (ALUOp_i == 3'b010) && ((funct_i == F_MULT) || (funct_i == F_MULTU) ||
                                        (funct_i == F_DIV)  || (funct_i == F_DIVU));
    is_signed = ~funct_i[0];
    start     = valid_i && is_md_op && (state_q == ST_IDLE);
    rs_abs    = (is_signed && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
    rt_abs    = (is_signed && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;
    shifted   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    trial     = shifted - {1'b0, opa_q};
    sum       = mq_q[0] ? (acc_q + {1'b0, opa_q}) : acc_q;
    prod      = {acc_q[WIDTH-1:0], mq_q};
    stall_o   = start || (state_q == ST_RUN);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_div_d  = funct_i[1];
          neg_d     = is_signed && (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
          rem_neg_d = is_signed && rs_data_i[WIDTH-1];
          dz_d      = funct_i[1] && (rt_data_i == {WIDTH{1'b0}});
          dvd_d     = rs_data_i;
          opa_d     = funct_i[1] ? rt_abs : rs_abs;
          mq_d      = funct_i[1] ? rs_abs : rt_abs;
          acc_d     = {(WIDTH+1){1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_RUN;
        end else if (valid_i && (ALUOp_i == 3'b010) && (funct_i == F_MTHI)) begin
          hi_d = rs_data_i;
        end else if (valid_i && (ALUOp_i == 3'b010) && (funct_i == F_MTLO)) begin
          lo_d = rs_data_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (op_div_q) begin
          if (!trial[WIDTH]) begin
            acc_d = trial;
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {acc_d, mq_d} = {1'b0, sum, mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        if (op_div_q) begin
          if (dz_q) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = dvd_q;
          end else begin
            lo_d = neg_q ? -mq_q : mq_q;
            hi_d = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end else begin
          {hi_d, lo_d} = neg_q ? -prod : prod;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and HI/LO registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      acc_q     <= {(WIDTH+1){1'b0}};
      mq_q      <= {WIDTH{1'b0}};
      opa_q     <= {WIDTH{1'b0}};
      dvd_q     <= {WIDTH{1'b0}};
      op_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opa_q     <= opa_d;
      dvd_q     <= dvd_d;
      op_div_q  <= op_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_md_alu_ctrl.sv
// Scoreboard bench for md_alu_ctrl: decode sweep, mult/div results and latency, mthi/mtlo, reset abort.
module tb_md_alu_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [5:0]   funct_i;
  logic [2:0]   ALUOp_i;
  logic         valid_i;
  logic [W-1:0] rs_data_i, rt_data_i;
  logic [3:0]   ALUCtrl_o;
  logic [W-1:0] md_result_o;
  logic         md_result_sel_o;
  logic         stall_o;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  md_alu_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i), .valid_i(valid_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .ALUCtrl_o(ALUCtrl_o),
    .md_result_o(md_result_o), .md_result_sel_o(md_result_sel_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: every cycle the DUT presents an mfhi/mflo result, compare against the scoreboard
  always @(negedge clk) begin
    if (!rst_i && md_result_sel_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected md result: got 0x%08h, expected nothing", md_result_o);
      end else begin
        check(name_q.pop_front(), md_result_o, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp_i = op; funct_i = f; valid_i = v; rs_data_i = a; rt_data_i = b;
  endtask

  task automatic expect_md(input string nm, input logic [W-1:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic dec(input logic [2:0] op, input logic [5:0] f, input logic [3:0] ctrl);
    logic sel;
    sel = (op == 3'b010) && ((f == F_MFHI) || (f == F_MFLO));
    @(posedge clk); #1;
    drive(op, f, 1'b0, 32'h0000_0000, 32'h0000_0000);
    if (sel) expect_md("decode md_result", 32'h0000_0000);
    @(negedge clk);
    check($sformatf("decode aluop=%b funct=%b ctrl", op, f), {28'd0, ALUCtrl_o}, {28'd0, ctrl});
    check($sformatf("decode aluop=%b funct=%b sel", op, f), {31'd0, md_result_sel_o}, {31'd0, sel});
  endtask

  task automatic read_hilo(input string nm, input logic [W-1:0] hi, input logic [W-1:0] lo);
    @(posedge clk); #1;
    drive(3'b010, F_MFHI, 1'b1, 32'h5555_5555, 32'hAAAA_AAAA);
    expect_md({nm, " HI"}, hi);
    @(negedge clk);
    check({nm, " stall on mfhi"}, {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    drive(3'b010, F_MFLO, 1'b1, 32'h5555_5555, 32'hAAAA_AAAA);
    expect_md({nm, " LO"}, lo);
    @(posedge clk); #1;
    drive(3'b010, F_ADD, 1'b0, 32'h0000_0000, 32'h0000_0000);
  endtask

  task automatic run_md(input string nm, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    drive(3'b010, f, 1'b1, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      cnt++;
      if (scramble && cnt > 1) begin
        rs_data_i = $urandom;
        rt_data_i = $urandom;
      end
    end
    check({nm, " stall cycles"}, cnt, 32'd33);
    read_hilo(nm, hi, lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    drive(3'b010, F_ADD, 1'b0, 32'h0000_0000, 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset stall", {31'd0, stall_o}, 32'd0);
    check("reset md_result", md_result_o, 32'h0000_0000);

    dec(3'b010, 6'b100000, 4'b0010);
    dec(3'b010, 6'b100010, 4'b0110);
    dec(3'b010, 6'b100100, 4'b0000);
    dec(3'b010, 6'b100101, 4'b0001);
    dec(3'b010, 6'b101010, 4'b0111);
    dec(3'b010, 6'b000000, 4'b0101);
    dec(3'b010, 6'b000110, 4'b1111);
    dec(3'b010, F_MULT,    4'b0000);
    dec(3'b010, F_MULTU,   4'b0000);
    dec(3'b010, F_DIV,     4'b0000);
    dec(3'b010, F_DIVU,    4'b0000);
    dec(3'b010, F_MFHI,    4'b0000);
    dec(3'b010, F_MTHI,    4'b0000);
    dec(3'b010, F_MFLO,    4'b0000);
    dec(3'b010, F_MTLO,    4'b0000);
    dec(3'b010, 6'b111111, 4'b0000);
    dec(3'b110, F_MFHI,    4'b0010);
    dec(3'b011, F_MFHI,    4'b0111);
    dec(3'b001, F_MFHI,    4'b0110);
    dec(3'b100, F_MFHI,    4'b0100);
    dec(3'b111, F_MFLO,    4'b0001);
    dec(3'b000, F_MFLO,    4'b1000);
    dec(3'b101, F_MFLO,    4'b0000);

    run_md("mult -3*5",    F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu",        F_MULTU, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1);
    run_md("divu 100/7",   F_DIVU,  32'd100,       32'd7,         1'b0, 32'd2,         32'd14);
    run_md("div -7/2",     F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div min/-1",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
    run_md("div 123/0",    F_DIV,   32'd123,       32'd0,         1'b0, 32'd123,       32'hFFFF_FFFF);
    run_md("mult scramble", F_MULT, 32'h0000_1234, 32'h0000_0010, 1'b1, 32'h0000_0000, 32'h0001_2340);
    run_md("div scramble", F_DIV,   32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    @(posedge clk); #1;
    drive(3'b010, F_MTHI, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000);
    @(negedge clk);
    check("mthi stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    drive(3'b010, F_MTLO, 1'b1, 32'h0000_0007, 32'h0000_0000);
    @(negedge clk);
    check("mtlo stall", {31'd0, stall_o}, 32'd0);
    read_hilo("mthi/mtlo", 32'hDEAD_BEEF, 32'h0000_0007);

    // Abort a running mult with reset ten cycles after start
    @(posedge clk); #1;
    drive(3'b010, F_MULT, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
    repeat (10) @(posedge clk);
    #1;
    rst_i = 1'b1;
    drive(3'b010, F_ADD, 1'b0, 32'h0000_0000, 32'h0000_0000);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("abort stall", {31'd0, stall_o}, 32'd0);
    read_hilo("abort", 32'h0000_0000, 32'h0000_0000);

    repeat (2) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
